// File: rtl/evha_dmem_ptw_arb.sv
// Arbitrates LSU and page-table-walker accesses onto one DMEM port; PTW has priority, one transaction in flight.
// Request reaches DMEM the cycle after capture; the response is routed combinationally to the owner, with an error returned on timeout.
module evha_dmem_ptw_arb #(
  parameter int XLEN   = 64,
  parameter int TO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req_i,
  input  logic            lsu_cmd_i,
  input  logic [1:0]      lsu_width_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_req_ack_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic [1:0]      lsu_resp_o,
  input  logic            ptw_req_i,
  input  logic            ptw_cmd_i,
  input  logic [XLEN-1:0] ptw_addr_i,
  output logic            ptw_rdy_o,
  output logic [XLEN-1:0] ptw_ldata_o,
  output logic            ptw_exc_o,
  output logic            dmem_req_o,
  output logic            dmem_cmd_o,
  output logic [1:0]      dmem_width_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_req_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic [1:0]      dmem_resp_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] TO_VAL = 8'(TO_CYC);

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              cap_cmd, cap_cmd_nxt;
  logic [1:0]        cap_width, cap_width_nxt;
  logic [XLEN-1:0]   cap_addr, cap_addr_nxt;
  logic [XLEN-1:0]   cap_wdata, cap_wdata_nxt;
  logic [1:0]        resp_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      cap_cmd   <= 1'b0;
      cap_width <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      cnt       <= cnt_nxt;
      cap_cmd   <= cap_cmd_nxt;
      cap_width <= cap_width_nxt;
      cap_addr  <= cap_addr_nxt;
      cap_wdata <= cap_wdata_nxt;
    end
  end

  // Reserved encoding 11 is folded into error.
  assign resp_eff = (dmem_resp_i == 2'b11) ? 2'b10 : dmem_resp_i;

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    cap_cmd_nxt   = cap_cmd;
    cap_width_nxt = cap_width;
    cap_addr_nxt  = cap_addr;
    cap_wdata_nxt = cap_wdata;
    lsu_req_ack_o = 1'b0;
    lsu_rdata_o   = '0;
    lsu_resp_o    = 2'b00;
    ptw_rdy_o     = 1'b0;
    ptw_ldata_o   = '0;
    ptw_exc_o     = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_cmd_o    = 1'b0;
    dmem_width_o  = 2'b00;
    dmem_addr_o   = '0;
    dmem_wdata_o  = '0;

    case (state)
      IDLE: begin
        if (ptw_req_i) begin
          cap_cmd_nxt   = ptw_cmd_i;
          cap_width_nxt = 2'b11;
          cap_addr_nxt  = ptw_addr_i;
          cap_wdata_nxt = '0;
          owner_nxt     = 1'b1;
          state_nxt     = REQ;
        end else if (lsu_req_i) begin
          cap_cmd_nxt   = lsu_cmd_i;
          cap_width_nxt = lsu_width_i;
          cap_addr_nxt  = lsu_addr_i;
          cap_wdata_nxt = lsu_wdata_i;
          owner_nxt     = 1'b0;
          lsu_req_ack_o = 1'b1;
          state_nxt     = REQ;
        end
      end
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_cmd_o   = cap_cmd;
        dmem_width_o = cap_width;
        dmem_addr_o  = cap_addr;
        dmem_wdata_o = cap_wdata;
        if (dmem_req_ack_i) begin
          cnt_nxt   = '0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_eff != 2'b00) begin
          if (owner) begin
            ptw_rdy_o   = 1'b1;
            ptw_ldata_o = dmem_rdata_i;
            ptw_exc_o   = (resp_eff == 2'b10);
          end else begin
            lsu_resp_o  = resp_eff;
            lsu_rdata_o = dmem_rdata_i;
          end
          state_nxt = IDLE;
        end else if (cnt == TO_VAL) begin
          if (owner) begin
            ptw_rdy_o = 1'b1;
            ptw_exc_o = 1'b1;
          end else begin
            lsu_resp_o = 2'b10;
          end
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A reset cycle abandons whatever is in flight: nothing is acked or delivered.
    if (rst) begin
      lsu_req_ack_o = 1'b0;
      lsu_rdata_o   = '0;
      lsu_resp_o    = 2'b00;
      ptw_rdy_o     = 1'b0;
      ptw_ldata_o   = '0;
      ptw_exc_o     = 1'b0;
      dmem_req_o    = 1'b0;
      dmem_cmd_o    = 1'b0;
      dmem_width_o  = 2'b00;
      dmem_addr_o   = '0;
      dmem_wdata_o  = '0;
    end
  end

endmodule

// File: doc/evha_dmem_ptw_arb.md
EVHA_DMEM_PTW_ARB -- requirements
Module: evha_dmem_ptw_arb

Interface
REQ-001 SHALL have parameter XLEN, default 64: data and address width.
REQ-002 SHALL have parameter TO_CYC, default 255, legal range 1..255: response timeout in cycles, held in an 8-bit counter.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have LSU request ports (inputs):
- lsu_req_i, 1
- lsu_cmd_i, 1: 1 = write
- lsu_width_i, 2: byte / half / word / dword
- lsu_addr_i, XLEN
- lsu_wdata_i, XLEN
REQ-006 SHALL have LSU response ports (outputs):
- lsu_req_ack_o, 1
- lsu_rdata_o, XLEN
- lsu_resp_o, 2: 00 idle, 01 ok, 10 error
REQ-007 SHALL have page-table-walker request ports (inputs):
- ptw_req_i, 1
- ptw_cmd_i, 1
- ptw_addr_i, XLEN
REQ-008 SHALL have page-table-walker response ports (outputs):
- ptw_rdy_o, 1: combined grant/valid pulse
- ptw_ldata_o, XLEN
- ptw_exc_o, 1
REQ-009 SHALL have DMEM request ports (outputs):
- dmem_req_o, 1
- dmem_cmd_o, 1
- dmem_width_o, 2
- dmem_addr_o, XLEN
- dmem_wdata_o, XLEN
REQ-010 SHALL have DMEM response ports (inputs):
- dmem_req_ack_i, 1
- dmem_rdata_i, XLEN
- dmem_resp_i, 2: same encoding as lsu_resp_o

Function
REQ-011 SHALL implement FSM states IDLE, REQ, RESP; the granted source SHALL be held in a 1-bit owner register (0 = LSU, 1 = PTW).
REQ-012 IDLE, ptw_req_i=1: SHALL capture the PTW cmd and addr, set width to dword and wdata to 0, set owner=PTW, and go to REQ.
REQ-013 IDLE, ptw_req_i=0 and lsu_req_i=1: SHALL capture all LSU fields, set owner=LSU, pulse lsu_req_ack_o for that cycle, and go to REQ.
REQ-014 Simultaneous PTW and LSU requests in IDLE: PTW SHALL win; the LSU request SHALL stay pending with no ack.
REQ-015 REQ: dmem_req_o SHALL be 1 and the dmem_* outputs SHALL be driven only from the capture registers; dmem_req_ack_i=1 SHALL move the FSM to RESP and clear the timeout counter.
REQ-016 RESP: dmem_req_o SHALL be 0; the timeout counter SHALL increment by 1 each cycle while dmem_resp_i=00.
REQ-017 RESP, dmem_resp_i=01 or 10: SHALL route a one-cycle response to the owner and return to IDLE in the same edge:
- owner=LSU: lsu_resp_o=dmem_resp_i, lsu_rdata_o=dmem_rdata_i.
- owner=PTW: ptw_rdy_o=1, ptw_ldata_o=dmem_rdata_i, ptw_exc_o=(dmem_resp_i==10).
REQ-018 RESP, counter reaches TO_CYC with no response: SHALL return an error to the owner (LSU: resp=10; PTW: rdy=1, exc=1, ldata=0) and return to IDLE.
- A dmem_resp_i arriving later SHALL be ignored.
REQ-019 dmem_resp_i=11: SHALL be treated as error (10).
REQ-020 A response SHALL never be routed to the non-owner; the non-owner's response outputs SHALL stay at idle values.
REQ-021 At most one transaction SHALL be outstanding; no new capture before returning to IDLE.
REQ-022 Minimum latency: request in cycle N; dmem_req_o in N+1; with ack in N+1 and response in N+2, the response is visible to the owner in N+2.
REQ-023 A request re-asserted in the cycle after IDLE is re-entered SHALL be arbitrated as new.
REQ-024 While idle, lsu_rdata_o and ptw_ldata_o SHALL be 0 (no stale data).

Reset
REQ-025 With rst=1 at a clock edge:
- FSM SHALL go to IDLE.
- Owner, counter and capture registers SHALL clear to 0.
- All outputs SHALL be 0 from the next cycle.
REQ-026 Reset in REQ or RESP SHALL abandon the transaction with no response to either source; a later dmem response SHALL be ignored.

Verification
REQ-027 LSU read only: addr 0x80001000, width dword; ack next cycle; resp 01, rdata 0xDEADBEEF_CAFEF00D one cycle later -> lsu_req_ack_o pulse at capture, lsu_resp_o=01 with that data for exactly one cycle.
REQ-028 PTW and LSU requesting in the same cycle -> PTW transaction on DMEM first with width=11; LSU acked only in the first IDLE cycle after the PTW ptw_rdy_o pulse.
REQ-029 PTW read, dmem_resp_i=10 -> ptw_rdy_o=1 and ptw_exc_o=1 for one cycle; lsu_resp_o stays 00.
REQ-030 TO_CYC=4, ack given, no response -> error to the owner 4 cycles after entering RESP; a response at cycle 6 produces no output.
REQ-031 rst asserted in RESP, then dmem_resp_i=01 -> no response pulses; dmem_req_o=0; next LSU request accepted normally.
REQ-032 dmem_req_ack_i held 0 for 10 cycles in REQ -> dmem_req_o and addr/cmd/width/wdata stable throughout; the counter does not run.
